// File: rtl/seg_msg_arbiter_if.sv
// Display-message bus between the requesters and seg_msg_arbiter.
// The master side drives the requests; the arbiter (slave) drives the display word and owner.
interface seg_msg_arbiter_if;
   logic [15:0] status_msg;
   logic        note_req;
   logic [15:0] note_msg;
   logic        note_ack;
   logic        alert_req;
   logic [15:0] alert_msg;
   logic [15:0] msg;
   logic [1:0]  grant;
   logic        busy;

   modport master (
      output status_msg, note_req, note_msg, alert_req, alert_msg,
      input  note_ack, msg, grant, busy
   );

   modport slave (
      input  status_msg, note_req, note_msg, alert_req, alert_msg,
      output note_ack, msg, grant, busy
   );
endinterface

// File: rtl/seg_msg_arbiter.sv
// Shares the seven-segment message word between status, held notes and preempting alerts.
// Optional SEG_ARB_ALERT_BLINK_EN: alert word alternates with status_msg on each tick.
module seg_msg_arbiter #(
   parameter logic [15:0] TICK_DIV    = 16'd50000,
   parameter logic [7:0]  HOLD_TICKS  = 8'd20,
   parameter logic [7:0]  ALERT_TICKS = 8'd40
) (
   input logic               clk,
   input logic               rst_n,
   seg_msg_arbiter_if.slave  bus
);

   localparam int unsigned MSG_W  = 16;
   localparam int unsigned TICK_W = 16;
   localparam int unsigned HOLD_W = 8;

   localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 16'd1);
   localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_TICKS - 8'd1);
   localparam logic [HOLD_W-1:0] ALERT_LAST = HOLD_W'(ALERT_TICKS - 8'd1);

   // State encoding doubles as the grant code.
   typedef enum logic [1:0] {
      ST_STATUS = 2'b00,
      ST_NOTE   = 2'b01,
      ST_ALERT  = 2'b10
   } state_e;

   state_e              state_q, state_d;
   logic [TICK_W-1:0]   tick_q, tick_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [MSG_W-1:0]    note_word_q, note_word_d;
   logic [MSG_W-1:0]    alert_word_q, alert_word_d;
   logic                resume_q, resume_d;
   logic [MSG_W-1:0]    msg_q, msg_d;
   logic [1:0]          grant_q, grant_d;
   logic                busy_q, busy_d;
   logic                note_ack_q, note_ack_d;

   logic                tick_fire;
   logic                note_exp;
   logic                alert_exp;
   logic                restart;

   assign tick_fire = (tick_q == TICK_LAST);
   assign note_exp  = tick_fire && (hold_q == HOLD_LAST);
   assign alert_exp = tick_fire && (hold_q == ALERT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_STATUS;
         tick_q       <= '0;
         hold_q       <= '0;
         note_word_q  <= '0;
         alert_word_q <= '0;
         resume_q     <= 1'b0;
         msg_q        <= '0;
         grant_q      <= 2'b00;
         busy_q       <= 1'b0;
         note_ack_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         tick_q       <= tick_d;
         hold_q       <= hold_d;
         note_word_q  <= note_word_d;
         alert_word_q <= alert_word_d;
         resume_q     <= resume_d;
         msg_q        <= msg_d;
         grant_q      <= grant_d;
         busy_q       <= busy_d;
         note_ack_q   <= note_ack_d;
      end
   end

   // Next-state, counters and the registered outputs for the cycle after the decision.
   always_comb begin
      state_d      = state_q;
      tick_d       = tick_q + TICK_W'(1);
      hold_d       = hold_q;
      note_word_d  = note_word_q;
      alert_word_d = alert_word_q;
      resume_d     = resume_q;
      note_ack_d   = 1'b0;
      restart      = 1'b0;
      msg_d        = bus.status_msg;
      grant_d      = 2'b00;
      busy_d       = 1'b0;

      if (tick_fire) begin
         tick_d = '0;
         hold_d = hold_q + HOLD_W'(1);
      end

      case (state_q)
         ST_STATUS: begin
            restart = 1'b1;
            if (bus.alert_req) begin
               state_d      = ST_ALERT;
               alert_word_d = bus.alert_msg;
            end else if (bus.note_req) begin
               state_d     = ST_NOTE;
               note_word_d = bus.note_msg;
               note_ack_d  = 1'b1;
            end
         end
         ST_NOTE: begin
            if (bus.alert_req) begin
               // Note word stays in note_word_q; resume restarts with a full hold.
               state_d      = ST_ALERT;
               alert_word_d = bus.alert_msg;
               resume_d     = 1'b1;
               restart      = 1'b1;
            end else if (note_exp) begin
               restart = 1'b1;
               if (bus.note_req) begin
                  note_word_d = bus.note_msg;
                  note_ack_d  = 1'b1;
               end else begin
                  state_d = ST_STATUS;
               end
            end
         end
         ST_ALERT: begin
            if (bus.alert_req) begin
               alert_word_d = bus.alert_msg;
               restart      = 1'b1;
            end else if (alert_exp) begin
               restart = 1'b1;
               if (resume_q) begin
                  state_d  = ST_NOTE;
                  resume_d = 1'b0;
               end else if (bus.note_req) begin
                  state_d     = ST_NOTE;
                  note_word_d = bus.note_msg;
                  note_ack_d  = 1'b1;
               end else begin
                  state_d = ST_STATUS;
               end
            end
         end
         default: begin
            state_d = ST_STATUS;
            restart = 1'b1;
         end
      endcase

      if (restart) begin
         tick_d = '0;
         hold_d = '0;
      end

      grant_d = 2'(state_d);
      busy_d  = (state_d != ST_STATUS);

      case (state_d)
         ST_NOTE:  msg_d = note_word_d;
`ifdef SEG_ARB_ALERT_BLINK_EN
         ST_ALERT: msg_d = hold_d[0] ? bus.status_msg : alert_word_d;
`else
         ST_ALERT: msg_d = alert_word_d;
`endif
         default:  msg_d = bus.status_msg;
      endcase
   end

   assign bus.msg      = msg_q;
   assign bus.grant    = grant_q;
   assign bus.busy     = busy_q;
   assign bus.note_ack = note_ack_q;

endmodule

// File: tb/tb_seg_msg_arbiter.sv
// Directed bench for seg_msg_arbiter with TICK_DIV=4, HOLD_TICKS=3, ALERT_TICKS=2.
module tb_seg_msg_arbiter;

   logic clk;
   logic rst_n;
   int   n_total;
   int   n_bad;
   int   cyc;
   int   acks;

   seg_msg_arbiter_if bus ();

   seg_msg_arbiter #(
      .TICK_DIV    (16'd4),
      .HOLD_TICKS  (8'd3),
      .ALERT_TICKS (8'd2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_total++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Cycles the current owner g keeps the display (current cycle included), acks seen meanwhile.
   task automatic run_len(input logic [1:0] g, output int cycles, output int n_ack);
      cycles = 1;
      n_ack  = 0;
      for (int i = 0; i < 40; i++) begin
         step(1);
         if (bus.note_ack) n_ack++;
         if (bus.grant != g) return;
         cycles++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_total = 0;
      n_bad   = 0;
      rst_n          = 1'b0;
      bus.status_msg = 16'h1234;
      bus.note_req   = 1'b0;
      bus.note_msg   = 16'h0000;
      bus.alert_req  = 1'b0;
      bus.alert_msg  = 16'h0000;

      // Reset and passthrough
      #22;
      chk("rst_msg",   32'(bus.msg), 32'h0000);
      chk("rst_grant", 32'(bus.grant), 32'h0);
      chk("rst_busy",  32'(bus.busy), 32'h0);
      chk("rst_ack",   32'(bus.note_ack), 32'h0);
      step(1);
      rst_n = 1'b1;
      step(1);
      chk("pass_1234", 32'(bus.msg), 32'h1234);
      bus.status_msg = 16'h4321;
      chk("pass_lat_hold", 32'(bus.msg), 32'h1234);
      step(1);
      chk("pass_4321", 32'(bus.msg), 32'h4321);

      // Note hold
      bus.note_req = 1'b1;
      bus.note_msg = 16'hABCD;
      step(1);
      chk("note_ack",   32'(bus.note_ack), 32'h1);
      chk("note_grant", 32'(bus.grant), 32'h1);
      chk("note_msg",   32'(bus.msg), 32'hABCD);
      chk("note_busy",  32'(bus.busy), 32'h1);
      bus.note_req = 1'b0;
      step(1);
      chk("note_ack_once", 32'(bus.note_ack), 32'h0);
      run_len(2'b01, cyc, acks);
      chk("note_len",   32'(cyc + 1), 32'd12);
      chk("note_acks",  32'(acks), 32'd0);
      chk("note_end_g", 32'(bus.grant), 32'h0);
      chk("note_end_m", 32'(bus.msg), 32'h4321);
      chk("note_end_b", 32'(bus.busy), 32'h0);

      // Preempt and resume
      bus.note_req = 1'b1;
      bus.note_msg = 16'hABCD;
      step(1);
      chk("pre_ack", 32'(bus.note_ack), 32'h1);
      bus.note_req = 1'b0;
      step(5);
      bus.alert_req = 1'b1;
      bus.alert_msg = 16'h7777;
      step(1);
      bus.alert_req = 1'b0;
      chk("pre_grant", 32'(bus.grant), 32'h2);
      chk("pre_msg",   32'(bus.msg), 32'h7777);
      chk("pre_ack0",  32'(bus.note_ack), 32'h0);
      run_len(2'b10, cyc, acks);
      chk("pre_alert_len", 32'(cyc), 32'd8);
      chk("res_grant", 32'(bus.grant), 32'h1);
      chk("res_msg",   32'(bus.msg), 32'hABCD);
      chk("res_noack", 32'(acks), 32'd0);
      run_len(2'b01, cyc, acks);
      chk("res_len",   32'(cyc), 32'd12);
      chk("res_end_g", 32'(bus.grant), 32'h0);

      // Simultaneous alert and note from status
      bus.alert_req = 1'b1;
      bus.alert_msg = 16'h7777;
      bus.note_req  = 1'b1;
      bus.note_msg  = 16'hBEEF;
      step(1);
      bus.alert_req = 1'b0;
      chk("sim_grant", 32'(bus.grant), 32'h2);
      chk("sim_ack0",  32'(bus.note_ack), 32'h0);
      run_len(2'b10, cyc, acks);
      chk("sim_alert_len", 32'(cyc), 32'd8);
      chk("sim_exp_ack",   32'(acks), 32'd1);
      chk("sim_note_msg",  32'(bus.msg), 32'hBEEF);
      bus.note_req = 1'b0;
      run_len(2'b01, cyc, acks);
      chk("sim_note_len",  32'(cyc), 32'd12);

      // Alert retrigger
      bus.alert_req = 1'b1;
      bus.alert_msg = 16'h7777;
      step(1);
      bus.alert_req = 1'b0;
      step(6);
      chk("rt_still", 32'(bus.grant), 32'h2);
      bus.alert_req = 1'b1;
      bus.alert_msg = 16'h5555;
      step(1);
      bus.alert_req = 1'b0;
      chk("rt_msg", 32'(bus.msg), 32'h5555);
      run_len(2'b10, cyc, acks);
      chk("rt_len",   32'(cyc), 32'd8);
      chk("rt_end_g", 32'(bus.grant), 32'h0);

      // Back-to-back notes with note_req held
      bus.note_req = 1'b1;
      bus.note_msg = 16'h1111;
      step(1);
      chk("b2b_ack1", 32'(bus.note_ack), 32'h1);
      bus.note_msg = 16'h2222;
      cyc = 0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         cyc++;
         if (bus.note_ack) break;
      end
      chk("b2b_gap",   32'(cyc), 32'd12);
      chk("b2b_grant", 32'(bus.grant), 32'h1);
      chk("b2b_msg",   32'(bus.msg), 32'h2222);
      bus.note_req = 1'b0;
      run_len(2'b01, cyc, acks);
      chk("b2b_last_len", 32'(cyc), 32'd12);

      // Alert display pattern over status 1234
      bus.status_msg = 16'h1234;
      bus.alert_req  = 1'b1;
      bus.alert_msg  = 16'h7777;
      step(1);
      bus.alert_req = 1'b0;
      for (int i = 0; i < 8; i++) begin
`ifdef SEG_ARB_ALERT_BLINK_EN
         chk($sformatf("blink_msg%0d", i), 32'(bus.msg), (i < 4) ? 32'h7777 : 32'h1234);
`else
         chk($sformatf("steady_msg%0d", i), 32'(bus.msg), 32'h7777);
`endif
         chk($sformatf("alert_grant%0d", i), 32'(bus.grant), 32'h2);
         step(1);
      end
      chk("alert_done", 32'(bus.grant), 32'h0);

      // Reset mid-operation drops pending resume
      bus.note_req = 1'b1;
      bus.note_msg = 16'hCAFE;
      step(1);
      bus.note_req = 1'b0;
      step(2);
      bus.alert_req = 1'b1;
      bus.alert_msg = 16'h9999;
      step(1);
      bus.alert_req = 1'b0;
      step(2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_msg",   32'(bus.msg), 32'h0000);
      chk("mid_rst_grant", 32'(bus.grant), 32'h0);
      chk("mid_rst_busy",  32'(bus.busy), 32'h0);
      step(1);
      rst_n = 1'b1;
      step(12);
      chk("post_rst_grant", 32'(bus.grant), 32'h0);
      chk("post_rst_msg",   32'(bus.msg), 32'h1234);
      chk("post_rst_ack",   32'(bus.note_ack), 32'h0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
